// File: rtl/spwm_carrier_gen_if.sv
// Carrier generator bus: control inputs and carrier/strobe outputs.
// SPWM_CARRIER_SYNC_EN adds the sync_in control line.
interface spwm_carrier_gen_if #(
    parameter int WIDTH   = 10,
    parameter int PRESC_W = 8,
    parameter int CNT_W   = 14
);
    logic               enable;
    logic [PRESC_W-1:0] presc_div;
`ifdef SPWM_CARRIER_SYNC_EN
    logic               sync_in;
`endif
    logic [WIDTH-1:0]   peak;
    logic [WIDTH-1:0]   carrier;
    logic               en_inc;
    logic               en_dec;
    logic [CNT_W-1:0]   cont_inc;
    logic [CNT_W-1:0]   cont_dec;
    logic               peak_pulse;
    logic               valley_pulse;

    modport master (
        output enable, presc_div,
`ifdef SPWM_CARRIER_SYNC_EN
               sync_in,
`endif
               peak,
        input  carrier, en_inc, en_dec, cont_inc, cont_dec,
               peak_pulse, valley_pulse
    );

    modport slave (
        input  enable, presc_div,
`ifdef SPWM_CARRIER_SYNC_EN
               sync_in,
`endif
               peak,
        output carrier, en_inc, en_dec, cont_inc, cont_dec,
               peak_pulse, valley_pulse
    );
endinterface

// File: rtl/spwm_carrier_gen.sv
// Triangular up/down SPWM carrier with prescaler, ramp counters and turn strobes.
// Optional SPWM_CARRIER_SYNC_EN: sync_in restarts the carrier at a valley.
module spwm_carrier_gen #(
    parameter int WIDTH   = 10,
    parameter int PRESC_W = 8,
    parameter int CNT_W   = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    spwm_carrier_gen_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   carrier_q, carrier_d;
    logic [WIDTH-1:0]   peak_sh_q, peak_sh_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] div_q, div_d;
    logic [CNT_W-1:0]   cinc_q, cinc_d;
    logic [CNT_W-1:0]   cdec_q, cdec_d;
    logic               ppulse_q, ppulse_d;
    logic               vpulse_q, vpulse_d;
    logic               en_inc_q, en_dec_q;

    logic [WIDTH-1:0]   peak_clamp;
    logic [WIDTH:0]     carrier_inc;
    logic               tick;
    logic               sync_hit;

    assign peak_clamp  = (bus.peak < WIDTH'(2)) ? WIDTH'(2) : bus.peak;
    assign carrier_inc = {1'b0, carrier_q} + (WIDTH+1)'(1);
    assign tick        = (presc_q == div_q);
`ifdef SPWM_CARRIER_SYNC_EN
    assign sync_hit    = bus.sync_in;
`else
    assign sync_hit    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        carrier_d = carrier_q;
        peak_sh_d = peak_sh_q;
        presc_d   = presc_q;
        div_d     = div_q;
        cinc_d    = cinc_q;
        cdec_d    = cdec_q;
        ppulse_d  = 1'b0;
        vpulse_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    state_d   = UP;
                    carrier_d = '0;
                    presc_d   = '0;
                    div_d     = bus.presc_div;
                    peak_sh_d = peak_clamp;
                end
            end
            UP, DOWN: begin
                if (!bus.enable) begin
                    state_d   = IDLE;
                    carrier_d = '0;
                    presc_d   = '0;
                end else if (sync_hit) begin
                    state_d   = UP;
                    carrier_d = '0;
                    presc_d   = '0;
                    div_d     = bus.presc_div;
                    peak_sh_d = peak_clamp;
                    vpulse_d  = 1'b1;
                end else if (!tick) begin
                    presc_d = presc_q + PRESC_W'(1);
                end else begin
                    // prescaler division only changes at a wrap
                    presc_d = '0;
                    div_d   = bus.presc_div;
                    if (state_q == UP) begin
                        if (carrier_inc >= {1'b0, peak_sh_q}) begin
                            carrier_d = peak_sh_q;
                            state_d   = DOWN;
                            ppulse_d  = 1'b1;
                            cinc_d    = cinc_q + CNT_W'(1);
                        end else begin
                            carrier_d = carrier_inc[WIDTH-1:0];
                        end
                    end else if (carrier_q <= WIDTH'(1)) begin
                        carrier_d = '0;
                        state_d   = UP;
                        vpulse_d  = 1'b1;
                        cdec_d    = cdec_q + CNT_W'(1);
                        peak_sh_d = peak_clamp;
                    end else begin
                        carrier_d = carrier_q - WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                carrier_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            carrier_q <= '0;
            peak_sh_q <= WIDTH'(2);
            presc_q   <= '0;
            div_q     <= '0;
            cinc_q    <= '0;
            cdec_q    <= '0;
            ppulse_q  <= 1'b0;
            vpulse_q  <= 1'b0;
            en_inc_q  <= 1'b0;
            en_dec_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            carrier_q <= carrier_d;
            peak_sh_q <= peak_sh_d;
            presc_q   <= presc_d;
            div_q     <= div_d;
            cinc_q    <= cinc_d;
            cdec_q    <= cdec_d;
            ppulse_q  <= ppulse_d;
            vpulse_q  <= vpulse_d;
            en_inc_q  <= (state_d == UP);
            en_dec_q  <= (state_d == DOWN);
        end
    end

    assign bus.carrier      = carrier_q;
    assign bus.en_inc       = en_inc_q;
    assign bus.en_dec       = en_dec_q;
    assign bus.cont_inc     = cinc_q;
    assign bus.cont_dec     = cdec_q;
    assign bus.peak_pulse   = ppulse_q;
    assign bus.valley_pulse = vpulse_q;
endmodule

// File: tb/tb_spwm_carrier_gen.sv
// Self-checking bench for spwm_carrier_gen: vector table, directed corners,
// and random stimulus against a position-in-period reference model.
module tb_spwm_carrier_gen;
    localparam int W  = 10;
    localparam int PW = 8;
    localparam int CW = 14;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spwm_carrier_gen_if #(.WIDTH(W), .PRESC_W(PW), .CNT_W(CW)) bus ();
    spwm_carrier_gen_if #(.WIDTH(W), .PRESC_W(PW), .CNT_W(SW)) bus_s ();

    spwm_carrier_gen #(.WIDTH(W), .PRESC_W(PW), .CNT_W(CW)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    spwm_carrier_gen #(.WIDTH(W), .PRESC_W(PW), .CNT_W(SW)) u_small (
        .clk(clk), .rst_n(rst_n), .bus(bus_s)
    );

    int total = 0;
    int bad   = 0;

    // model: position within one period (0..2*ps-1) plus prescaler phase
    int m_run, m_pos, m_ps, m_sub, m_div, m_cinc, m_cdec, m_pp, m_vp;

    typedef struct {
        int en; int dv; int pk;
        int car; int inc; int dec; int pp; int vp;
    } vec_t;
    vec_t tv[16];

    task automatic check(string name, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_ps = 2; m_sub = 0; m_div = 0;
        m_cinc = 0; m_cdec = 0; m_pp = 0; m_vp = 0;
    endtask

    task automatic model_step();
        int pk;
        pk = (int'(bus.peak) < 2) ? 2 : int'(bus.peak);
        m_pp = 0;
        m_vp = 0;
        if (bus.enable == 1'b0) begin
            m_run = 0; m_pos = 0; m_sub = 0;
        end else if (m_run == 0) begin
            m_run = 1; m_pos = 0; m_sub = 0;
            m_ps = pk; m_div = int'(bus.presc_div);
        end
`ifdef SPWM_CARRIER_SYNC_EN
        else if (bus.sync_in) begin
            m_pos = 0; m_sub = 0; m_ps = pk;
            m_div = int'(bus.presc_div); m_vp = 1;
        end
`endif
        else if (m_sub == m_div) begin
            m_sub = 0;
            m_div = int'(bus.presc_div);
            m_pos++;
            if (m_pos == m_ps) begin
                m_pp = 1;
                m_cinc = (m_cinc + 1) % (1 << CW);
            end else if (m_pos == 2 * m_ps) begin
                m_pos = 0;
                m_vp = 1;
                m_cdec = (m_cdec + 1) % (1 << CW);
                m_ps = pk;
            end
        end else begin
            m_sub++;
        end
    endtask

    function automatic longint dut_obs();
        return longint'({bus.carrier, bus.en_inc, bus.en_dec,
            bus.peak_pulse, bus.valley_pulse, bus.cont_inc, bus.cont_dec});
    endfunction

    function automatic longint model_obs();
        int c;
        c = (m_run == 0) ? 0 : (m_pos <= m_ps) ? m_pos : 2 * m_ps - m_pos;
        return longint'({W'(c), 1'(m_run != 0 && m_pos < m_ps),
            1'(m_run != 0 && m_pos >= m_ps), 1'(m_pp), 1'(m_vp),
            CW'(m_cinc), CW'(m_cdec)});
    endfunction

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(string name);
        check(name, dut_obs(), model_obs());
    endtask

    task automatic wait_for(string name, int kind, int val);
        int n;
        bit hit;
        n = 0;
        hit = 0;
        while (!hit && n < 80) begin
            cyc();
            check_model({name, "_model"});
            n++;
            if (kind == 0) hit = (bus.en_inc && int'(bus.carrier) == val);
            else hit = (bus.en_dec && int'(bus.carrier) == val);
        end
        check({name, "_reach"}, longint'(hit), 1);
    endtask

    initial begin
        int ci, cd;
        int seen[$];
        tv[0]  = '{1, 0, 4, 0, 1, 0, 0, 0};
        tv[1]  = '{1, 0, 4, 1, 1, 0, 0, 0};
        tv[2]  = '{1, 0, 4, 2, 1, 0, 0, 0};
        tv[3]  = '{1, 0, 4, 3, 1, 0, 0, 0};
        tv[4]  = '{1, 0, 4, 4, 0, 1, 1, 0};
        tv[5]  = '{1, 0, 4, 3, 0, 1, 0, 0};
        tv[6]  = '{1, 0, 4, 2, 0, 1, 0, 0};
        tv[7]  = '{1, 0, 4, 1, 0, 1, 0, 0};
        tv[8]  = '{1, 0, 4, 0, 1, 0, 0, 1};
        tv[9]  = '{1, 0, 4, 1, 1, 0, 0, 0};
        tv[10] = '{0, 0, 0, 0, 0, 0, 0, 0};
        tv[11] = '{1, 0, 0, 0, 1, 0, 0, 0};
        tv[12] = '{1, 0, 1, 1, 1, 0, 0, 0};
        tv[13] = '{1, 0, 1, 2, 0, 1, 1, 0};
        tv[14] = '{1, 0, 1, 1, 0, 1, 0, 0};
        tv[15] = '{1, 0, 0, 0, 1, 0, 0, 1};

        rst_n = 1'b0;
        bus.enable = 1'b0; bus.presc_div = '0; bus.peak = '0;
        bus_s.enable = 1'b0; bus_s.presc_div = '0; bus_s.peak = '0;
`ifdef SPWM_CARRIER_SYNC_EN
        bus.sync_in = 1'b0;
        bus_s.sync_in = 1'b0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset", dut_obs(), 0);
        rst_n = 1'b1;
        cyc();
        check("idle_hold", dut_obs(), 0);

        // T2 / T5 waveform table
        for (int i = 0; i < 16; i++) begin
            bus.enable    = tv[i].en[0];
            bus.presc_div = PW'(tv[i].dv);
            bus.peak      = W'(tv[i].pk);
            cyc();
            check($sformatf("tv%0d", i),
                longint'({W'(tv[i].car), 1'(tv[i].inc), 1'(tv[i].dec),
                    1'(tv[i].pp), 1'(tv[i].vp)}),
                longint'({bus.carrier, bus.en_inc, bus.en_dec,
                    bus.peak_pulse, bus.valley_pulse}));
        end
        check("tv_cnt", longint'({bus.cont_inc, bus.cont_dec}),
            longint'({CW'(2), CW'(2)}));

        // T3: presc_div=2, peak=3, three periods of 18 clks
        bus.enable = 1'b0;
        cyc();
        ci = int'(bus.cont_inc);
        cd = int'(bus.cont_dec);
        bus.enable = 1'b1; bus.presc_div = PW'(2); bus.peak = W'(3);
        for (int i = 0; i < 55; i++) begin
            cyc();
            check_model("t3_model");
        end
        check("t3_inc", int'(bus.cont_inc), ci + 3);
        check("t3_dec", int'(bus.cont_dec), cd + 3);
        check("t3_valley", longint'({bus.carrier, bus.en_inc}),
            longint'({W'(0), 1'b1}));

        // T4: peak raised mid-ramp takes effect only after the valley
        bus.enable = 1'b0;
        cyc();
        bus.enable = 1'b1; bus.presc_div = '0; bus.peak = W'(4);
        wait_for("t4", 0, 2);
        bus.peak = W'(6);
        for (int i = 0; i < 40 && seen.size() < 2; i++) begin
            cyc();
            check_model("t4_model");
            if (bus.peak_pulse) seen.push_back(int'(bus.carrier));
        end
        check("t4_first", (seen.size() > 0) ? seen[0] : -1, 4);
        check("t4_second", (seen.size() > 1) ? seen[1] : -1, 6);

        // T6: enable drop and resume
        bus.peak = W'(8);
        wait_for("t6", 0, 3);
        ci = int'(bus.cont_inc);
        cd = int'(bus.cont_dec);
        bus.enable = 1'b0;
        cyc();
        check("t6_off", longint'({bus.carrier, bus.en_inc, bus.en_dec,
            bus.peak_pulse, bus.valley_pulse}), 0);
        check("t6_cnt", longint'({bus.cont_inc, bus.cont_dec}),
            longint'({CW'(ci), CW'(cd)}));
        bus.enable = 1'b1;
        cyc();
        check("t6_on", longint'({bus.carrier, bus.en_inc, bus.en_dec}),
            longint'({W'(0), 2'b10}));
        cyc();
        check("t6_step", int'(bus.carrier), 1);
        check_model("t6_model");
`ifdef SPWM_CARRIER_SYNC_EN
        wait_for("t6s", 1, 5);
        ci = int'(bus.cont_inc);
        cd = int'(bus.cont_dec);
        bus.sync_in = 1'b1;
        cyc();
        bus.sync_in = 1'b0;
        check("t6_sync", longint'({bus.carrier, bus.en_inc, bus.en_dec,
            bus.valley_pulse}), longint'({W'(0), 3'b101}));
        check("t6_sync_cnt", longint'({bus.cont_inc, bus.cont_dec}),
            longint'({CW'(ci), CW'(cd)}));
`endif

        // T1: asynchronous reset between clock edges
        wait_for("t1", 0, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_async", dut_obs(), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // random stimulus against the model
        bus.enable = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) bus.enable = 1'b0;
            else if ($urandom_range(0, 3) == 0) bus.enable = 1'b1;
            if ($urandom_range(0, 40) == 0) bus.presc_div = PW'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) bus.peak = W'($urandom_range(0, 12));
`ifdef SPWM_CARRIER_SYNC_EN
            bus.sync_in = ($urandom_range(0, 99) == 0);
`endif
            cyc();
            check_model("rand");
        end
`ifdef SPWM_CARRIER_SYNC_EN
        bus.sync_in = 1'b0;
`endif

        // T5 on the narrow-counter instance: clamped peak and counter wrap
        bus.enable = 1'b0;
        bus_s.enable = 1'b1; bus_s.presc_div = '0; bus_s.peak = W'(1);
        cyc();
        check("t5_start", longint'({bus_s.carrier, bus_s.en_inc}),
            longint'({W'(0), 1'b1}));
        for (int e = 1; e <= 64; e++) begin
            cyc();
            if (e == 1) check("t5_c1", int'(bus_s.carrier), 1);
            if (e == 2) check("t5_c2", longint'({bus_s.carrier, bus_s.peak_pulse}),
                longint'({W'(2), 1'b1}));
            if (e == 3) check("t5_c3", int'(bus_s.carrier), 1);
            if (e == 4) check("t5_c4", longint'({bus_s.carrier, bus_s.valley_pulse}),
                longint'({W'(0), 1'b1}));
            if (e == 61) check("t5_inc15", int'(bus_s.cont_inc), 15);
            if (e == 62) check("t5_inc_wrap", int'(bus_s.cont_inc), 0);
            if (e == 64) check("t5_dec_wrap", int'(bus_s.cont_dec), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
